time_entry: RTL and testbench

Consumer end of the keypad encoder interface in the microwave controller. Captures BCD digits presented on `D` with the active-low `loadn` strobe, shifts them into a four-digit MM:SS time register, and counts that time down to 00:00 on `pgt_1hz` ticks once cooking starts. Drives `enablen` back to the encoder so the keypad is locked while the timer runs or is paused. Exposes the digits for the display driver and the run/done status for the magnetron and buzzer logic.

---
 rtl/time_entry.sv | 146 ++++++++++++++
 tb/tb_time_entry.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry.sv
// Microwave cook-time entry: captures keypad BCD digits into an MM:SS register
// and counts it down on 1 Hz ticks, with run/pause/done control and keypad lockout.
module time_entry (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       enablen,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e     state_q, state_d;
  logic       loadn_q, startn_q, stopn_q, pgt_q;
  logic       loadEv_q, startEv_q, stopEv_q, tickEv_q;
  logic [3:0] dig_q;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [3:0] decMt, decMo, decSt, decSo;
  logic       decZero, timeZero;

  // Edge detection is itself registered, which gives the two-edge event latency.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      loadn_q   <= 1'b1;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
      pgt_q     <= 1'b0;
      loadEv_q  <= 1'b0;
      startEv_q <= 1'b0;
      stopEv_q  <= 1'b0;
      tickEv_q  <= 1'b0;
      dig_q     <= 4'd0;
    end else begin
      loadn_q   <= loadn;
      startn_q  <= startn;
      stopn_q   <= stopn;
      pgt_q     <= pgt_1hz;
      loadEv_q  <= loadn_q & ~loadn;
      startEv_q <= startn_q & ~startn;
      stopEv_q  <= stopn_q & ~stopn;
      tickEv_q  <= ~pgt_q & pgt_1hz;
      dig_q     <= D;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
    end
  end

  // One-second decrement; seconds-tens wraps to 5, so entered 6-9 simply count down.
  always_comb begin
    decMt = mt_q;
    decMo = mo_q;
    decSt = st_q;
    decSo = so_q;
    if (so_q != 4'd0) begin
      decSo = so_q - 4'd1;
    end else begin
      decSo = 4'd9;
      if (st_q != 4'd0) begin
        decSt = st_q - 4'd1;
      end else begin
        decSt = 4'd5;
        if (mo_q != 4'd0) begin
          decMo = mo_q - 4'd1;
        end else begin
          decMo = 4'd9;
          decMt = mt_q - 4'd1;
        end
      end
    end
  end

  assign timeZero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
  assign decZero  = ({decMt, decMo, decSt, decSo} == 16'h0000);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    unique case (state_q)
      IDLE: begin
        if (stopEv_q) begin
          {mt_d, mo_d, st_d, so_d} = 16'h0000;
        end else if (startEv_q && !timeZero) begin
          state_d = RUN;
        end else if (loadEv_q && dig_q <= 4'd9) begin
          {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, dig_q};
        end
      end
      RUN: begin
        if (stopEv_q) begin
          state_d = PAUSE;
        end else if (tickEv_q) begin
          {mt_d, mo_d, st_d, so_d} = {decMt, decMo, decSt, decSo};
          if (decZero) state_d = DONE;
        end
      end
      PAUSE: begin
        if (stopEv_q) begin
          state_d = IDLE;
          {mt_d, mo_d, st_d, so_d} = 16'h0000;
        end else if (startEv_q) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stopEv_q || startEv_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign enablen  = (state_q == RUN) || (state_q == PAUSE);
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed scenarios plus a random event
// stream compared against a digit-list reference model.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       clrn;
  logic [3:0] D;
  logic       loadn, pgt_1hz, startn, stopn;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       enablen, running, done;

  int nVec = 0;
  int nErr = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int EV_LOAD = 0, EV_START = 1, EV_STOP = 2, EV_TICK = 3, EV_BOTH = 4;

  int tq[$];
  int mode;

  time_entry dut (
    .clk(clk), .clrn(clrn), .D(D), .loadn(loadn), .pgt_1hz(pgt_1hz),
    .startn(startn), .stopn(stopn),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .enablen(enablen), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: time is a list of four digits, most significant first.
  function automatic void mReset();
    tq = '{0, 0, 0, 0};
    mode = M_IDLE;
  endfunction

  function automatic bit mZero();
    return (tq[0] + tq[1] + tq[2] + tq[3]) == 0;
  endfunction

  function automatic void mDecrement();
    int radix[4] = '{10, 10, 6, 10};
    for (int i = 3; i >= 0; i--) begin
      if (tq[i] != 0) begin
        tq[i] = tq[i] - 1;
        break;
      end
      tq[i] = radix[i] - 1;
    end
  endfunction

  function automatic void mEvent(input int kind, input int d);
    int k;
    k = (kind == EV_BOTH) ? EV_STOP : kind;
    case (mode)
      M_IDLE: begin
        if (k == EV_STOP) tq = '{0, 0, 0, 0};
        else if (k == EV_START && !mZero()) mode = M_RUN;
        else if (k == EV_LOAD && d <= 9) begin
          void'(tq.pop_front());
          tq.push_back(d);
        end
      end
      M_RUN: begin
        if (k == EV_STOP) mode = M_PAUSE;
        else if (k == EV_TICK) begin
          mDecrement();
          if (mZero()) mode = M_DONE;
        end
      end
      M_PAUSE: begin
        if (k == EV_STOP) begin
          tq = '{0, 0, 0, 0};
          mode = M_IDLE;
        end else if (k == EV_START) mode = M_RUN;
      end
      default: begin
        if (k == EV_STOP || k == EV_START) mode = M_IDLE;
      end
    endcase
  endfunction

  function automatic logic [18:0] expVec();
    return {4'(tq[0]), 4'(tq[1]), 4'(tq[2]), 4'(tq[3]),
            (mode == M_RUN || mode == M_PAUSE), (mode == M_RUN), (mode == M_DONE)};
  endfunction

  function automatic logic [18:0] actVec();
    return {min_tens, min_ones, sec_tens, sec_ones, enablen, running, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert one input event for a random hold time, release it, then settle.
  task automatic applyStimulus(input int kind, input logic [3:0] d);
    int hold;
    hold = $urandom_range(1, 4);
    D = d;
    case (kind)
      EV_LOAD:  loadn = 1'b0;
      EV_START: startn = 1'b0;
      EV_STOP:  stopn = 1'b0;
      EV_TICK:  pgt_1hz = 1'b1;
      default: begin
        startn = 1'b0;
        stopn = 1'b0;
      end
    endcase
    repeat (hold) step();
    loadn = 1'b1;
    startn = 1'b1;
    stopn = 1'b1;
    pgt_1hz = 1'b0;
    repeat (2) step();
    mEvent(kind, int'(d));
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    D = 4'd0;
    loadn = 1'b1;
    startn = 1'b1;
    stopn = 1'b1;
    pgt_1hz = 1'b0;
    mReset();
    #22;
    nVec++;
    if (actVec() !== 19'd0) begin
      nErr++;
      $display("[TB] FAIL reset_state: got %h expected %h", actVec(), 19'd0);
    end
    clrn = 1'b1;
    step();
  endtask

  task automatic test_load();
    logic [3:0] seq[3] = '{4'd2, 4'd3, 4'd0};
    loadn = 1'b0;
    D = 4'd1;
    step();
    nVec++;
    if (sec_ones !== 4'd0) begin
      nErr++;
      $display("[TB] FAIL load_latency_edge1: got %0d expected 0", sec_ones);
    end
    step();
    nVec++;
    if (sec_ones !== 4'd1) begin
      nErr++;
      $display("[TB] FAIL load_latency_edge2: got %0d expected 1", sec_ones);
    end
    repeat (3) step();
    loadn = 1'b1;
    step();
    mEvent(EV_LOAD, 1);
    foreach (seq[i]) applyStimulus(EV_LOAD, seq[i]);
    nVec++;
    if (actVec() !== {16'h1230, 3'b000}) begin
      nErr++;
      $display("[TB] FAIL load_1230: got %h expected %h", actVec(), {16'h1230, 3'b000});
    end
  endtask

  task automatic test_shift_invalid();
    logic [3:0] seq[5] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    foreach (seq[i]) applyStimulus(EV_LOAD, seq[i]);
    nVec++;
    if (actVec() !== {16'h8765, 3'b000}) begin
      nErr++;
      $display("[TB] FAIL shift_8765: got %h expected %h", actVec(), {16'h8765, 3'b000});
    end
    applyStimulus(EV_LOAD, 4'd12);
    nVec++;
    if (actVec() !== expVec()) begin
      nErr++;
      $display("[TB] FAIL invalid_digit: got %h expected %h", actVec(), expVec());
    end
  endtask

  task automatic test_countdown();
    logic [15:0] want[3] = '{16'h0002, 16'h0001, 16'h0000};
    applyStimulus(EV_STOP, 4'd0);
    applyStimulus(EV_LOAD, 4'd3);
    applyStimulus(EV_START, 4'd0);
    nVec++;
    if (actVec() !== {16'h0003, 3'b110}) begin
      nErr++;
      $display("[TB] FAIL start_run: got %h expected %h", actVec(), {16'h0003, 3'b110});
    end
    foreach (want[i]) begin
      applyStimulus(EV_TICK, 4'd0);
      nVec++;
      if (actVec() !== expVec() || actVec()[18:3] !== want[i]) begin
        nErr++;
        $display("[TB] FAIL countdown_tick%0d: got %h expected %h", i, actVec(), expVec());
      end
    end
    nVec++;
    if (actVec() !== {16'h0000, 3'b001}) begin
      nErr++;
      $display("[TB] FAIL done_flag: got %h expected %h", actVec(), {16'h0000, 3'b001});
    end
    applyStimulus(EV_STOP, 4'd0);
    nVec++;
    if (actVec() !== expVec()) begin
      nErr++;
      $display("[TB] FAIL done_to_idle: got %h expected %h", actVec(), expVec());
    end
  endtask

  task automatic test_borrow();
    logic [3:0] a[4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic [3:0] b[4] = '{4'd0, 4'd0, 4'd9, 4'd0};
    foreach (a[i]) applyStimulus(EV_LOAD, a[i]);
    applyStimulus(EV_START, 4'd0);
    applyStimulus(EV_TICK, 4'd0);
    nVec++;
    if (actVec() !== {16'h0959, 3'b110}) begin
      nErr++;
      $display("[TB] FAIL borrow_0959: got %h expected %h", actVec(), {16'h0959, 3'b110});
    end
    applyStimulus(EV_STOP, 4'd0);
    applyStimulus(EV_STOP, 4'd0);
    foreach (b[i]) applyStimulus(EV_LOAD, b[i]);
    applyStimulus(EV_START, 4'd0);
    applyStimulus(EV_TICK, 4'd0);
    nVec++;
    if (actVec() !== {16'h0089, 3'b110}) begin
      nErr++;
      $display("[TB] FAIL sec_tens_90: got %h expected %h", actVec(), {16'h0089, 3'b110});
    end
    applyStimulus(EV_STOP, 4'd0);
    applyStimulus(EV_STOP, 4'd0);
  endtask

  task automatic test_pause();
    logic [3:0] a[3] = '{4'd5, 4'd0, 4'd0};
    foreach (a[i]) applyStimulus(EV_LOAD, a[i]);
    applyStimulus(EV_START, 4'd0);
    applyStimulus(EV_STOP, 4'd0);
    nVec++;
    if (actVec() !== {16'h0500, 3'b100}) begin
      nErr++;
      $display("[TB] FAIL pause_state: got %h expected %h", actVec(), {16'h0500, 3'b100});
    end
    applyStimulus(EV_LOAD, 4'd7);
    applyStimulus(EV_TICK, 4'd0);
    applyStimulus(EV_START, 4'd0);
    nVec++;
    if (actVec() !== {16'h0500, 3'b110}) begin
      nErr++;
      $display("[TB] FAIL resume_run: got %h expected %h", actVec(), {16'h0500, 3'b110});
    end
    applyStimulus(EV_STOP, 4'd0);
    applyStimulus(EV_STOP, 4'd0);
    nVec++;
    if (actVec() !== {16'h0000, 3'b000}) begin
      nErr++;
      $display("[TB] FAIL pause_clear: got %h expected %h", actVec(), {16'h0000, 3'b000});
    end
  endtask

  task automatic test_start_zero_and_both();
    logic [3:0] a[3] = '{4'd1, 4'd0, 4'd0};
    applyStimulus(EV_START, 4'd0);
    nVec++;
    if (actVec() !== {16'h0000, 3'b000}) begin
      nErr++;
      $display("[TB] FAIL start_at_zero: got %h expected %h", actVec(), {16'h0000, 3'b000});
    end
    foreach (a[i]) applyStimulus(EV_LOAD, a[i]);
    applyStimulus(EV_BOTH, 4'd0);
    nVec++;
    if (actVec() !== {16'h0000, 3'b000}) begin
      nErr++;
      $display("[TB] FAIL stop_beats_start: got %h expected %h", actVec(), {16'h0000, 3'b000});
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] a[2] = '{4'd4, 4'd2};
    foreach (a[i]) applyStimulus(EV_LOAD, a[i]);
    applyStimulus(EV_START, 4'd0);
    applyStimulus(EV_TICK, 4'd0);
    clrn = 1'b0;
    #2;
    nVec++;
    if (actVec() !== 19'd0) begin
      nErr++;
      $display("[TB] FAIL async_clear: got %h expected %h", actVec(), 19'd0);
    end
    #5;
    clrn = 1'b1;
    mReset();
    step();
  endtask

  task automatic test_random();
    int kind;
    int r;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) kind = EV_LOAD;
      else if (r < 5) kind = EV_START;
      else if (r < 6) kind = EV_STOP;
      else if (r < 9) kind = EV_TICK;
      else kind = EV_BOTH;
      applyStimulus(kind, 4'($urandom_range(0, 15)));
      nVec++;
      if (actVec() !== expVec()) begin
        nErr++;
        $display("[TB] FAIL random_%0d_ev%0d: got %h expected %h", n, kind, actVec(), expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_invalid();
    test_countdown();
    test_borrow();
    test_pause();
    test_start_zero_and_both();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
